// File: rtl/sobel_uart_tx_if.sv
`timescale 1ns/1ps
// Pixel stream from the Sobel controller into the UART transmitter.
// Latency: n/a (wiring only).
// Backpressure: none; the stream is push-only and the consumer drops on overflow.
// Ports: pi_flag  one-cycle valid strobe per byte
//        pi_data  pixel byte, meaningful while pi_flag=1
interface sobel_uart_tx_if;
  logic       pi_flag;
  logic [7:0] pi_data;

  modport master (output pi_flag, output pi_data);
  modport slave  (input  pi_flag, input  pi_data);
endinterface

// File: rtl/sobel_uart_tx.sv
`timescale 1ns/1ps
// Buffers the binarized Sobel pixel stream and serializes each byte as UART 8N1 (8E1 with parity).
// Latency: flag sampled at edge 0 into an empty FIFO -> start bit driven after edge 2.
// Backpressure: none upstream; bytes arriving with the FIFO full (and no pop) are dropped, po_overflow sticks.
//
// Ports: sys_clk/sys_rst_n  clock, async active-low reset
//        pix (slave)        pi_flag/pi_data pixel stream
//        tx                 serial line, idles high
//        po_busy            FIFO non-empty or transmitter active
//        po_overflow        sticky drop indicator, cleared only by reset
//        frame_done         one-cycle pulse at the end of the stop bit of the last byte of a frame
// Option: define SOBEL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module sobel_uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 16,      // power of 2, >= 4
  parameter int FRAME_PIX  = 9604
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  sobel_uart_tx_if.slave pix,
  output logic           tx,
  output logic           po_busy,
  output logic           po_overflow,
  output logic           frame_done
);

  localparam int BAUD_MAX = CLK_FREQ / UART_BPS - 1;
  localparam int BAUD_W   = (BAUD_MAX > 0) ? $clog2(BAUD_MAX + 1) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int FR_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
`ifdef SOBEL_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP  = 3'd5
  } state_t;

  state_t state, state_nxt;

  // ------------------------------------------------------------------
  // FIFO: pointers carry one extra wrap bit so full and empty differ.
  // ------------------------------------------------------------------
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  mem [FIFO_DEPTH];
  logic        fifo_empty, fifo_full;
  logic        push_vld, pop_vld;
  logic [7:0]  pop_dat;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_vld   = pix.pi_flag && (!fifo_full || pop_vld);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      po_overflow <= 1'b0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop_vld)  rd_ptr <= rd_ptr + 1'b1;
      if (pix.pi_flag && !push_vld) po_overflow <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_vld) mem[wr_ptr[AW-1:0]] <= pix.pi_data;
  end

  // ------------------------------------------------------------------
  // Transmitter datapath
  // ------------------------------------------------------------------
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        tx_byte;
  logic [FR_W-1:0]   frame_cnt;
  logic              baud_end;

  assign baud_end = (baud_cnt == BAUD_W'(BAUD_MAX));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      pop_dat   <= '0;
      tx_byte   <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;

      // The slot is released at the pop edge and may be rewritten before LOAD,
      // so the byte is captured here.
      if (pop_vld) pop_dat <= mem[rd_ptr[AW-1:0]];

      if (state == ST_LOAD) begin
        tx_byte  <= pop_dat;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (state == ST_IDLE) begin
        baud_cnt <= '0;
      end else if (baud_end) begin
        baud_cnt <= '0;
        if (state == ST_DATA) bit_idx <= bit_idx + 1'b1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state == ST_STOP && baud_end) begin
        if (frame_done) frame_cnt <= '0;
        else            frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Next state and line level. tx is decoded from registered state so an
  // async reset forces the line high immediately.
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    pop_vld    = 1'b0;
    tx         = 1'b1;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_vld   = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: state_nxt = ST_START;
      ST_START: begin
        tx = 1'b0;
        if (baud_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = tx_byte[bit_idx];
`ifdef SOBEL_TX_PARITY_EN
        if (baud_end && bit_idx == 3'd7) state_nxt = ST_PARITY;
`else
        if (baud_end && bit_idx == 3'd7) state_nxt = ST_STOP;
`endif
      end
`ifdef SOBEL_TX_PARITY_EN
      ST_PARITY: begin
        tx = ^tx_byte;
        if (baud_end) state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          state_nxt  = ST_IDLE;
          frame_done = (frame_cnt == FR_W'(FRAME_PIX - 1));
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign po_busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_sobel_uart_tx.sv
`timescale 1ns/1ps
// Bench for sobel_uart_tx: records every output each cycle and compares the
// whole trace against an event-level model (byte queue + frame timing).
// Ports: drives sys_clk, sys_rst_n and the pixel interface; observes all outputs.
module tb_sobel_uart_tx;
  localparam int CLK_FREQ   = 50_000_000;
  localparam int UART_BPS   = 5_000_000;
  localparam int FIFO_DEPTH = 16;
  localparam int FRAME_PIX  = 4;
  localparam int BIT_CLKS   = CLK_FREQ / UART_BPS;
`ifdef SOBEL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * BIT_CLKS;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic tx, po_busy, po_overflow, frame_done;

  sobel_uart_tx_if pix();

  sobel_uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_BPS  (UART_BPS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FRAME_PIX (FRAME_PIX)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pix        (pix),
    .tx         (tx),
    .po_busy    (po_busy),
    .po_overflow(po_overflow),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Sample index k holds the outputs just after rising edge k: {ovf, busy, fd, tx}.
  logic [3:0] obs_log[$];
  always @(posedge sys_clk) begin
    #1;
    obs_log.push_back({po_overflow, po_busy, frame_done, tx});
  end

  // Stimulus for one case: idle cycles before each pulse, and its byte.
  int         stim_gap[$];
  logic [7:0] stim_dat[$];
  int         edges[$];

  logic exp_tx[$], exp_fd[$], exp_busy[$], exp_ovf[$];

  function automatic logic bit_level(input logic [7:0] b, input int j);
    if (j == 0)         return 1'b0;
    if (j <= 8)         return b[j-1];
    if (j == NBITS - 1) return 1'b1;
    return ^b;
  endfunction

  // Reference: bytes queue in arrival order; the transmitter takes one when
  // it has been idle for a cycle, the line carries it from the next cycle
  // for FRAME_CLKS cycles, and every FRAME_PIX-th byte ends a frame.
  task automatic model(input int n0, input int n1);
    logic [7:0] q[$];
    logic [7:0] b;
    int idle_from, k, sent, s, len, idx;
    logic ovf;
    bit pop;
    len = n1 - n0;
    idle_from = n0 - 1; k = 0; sent = 0; ovf = 1'b0;
    exp_tx.delete(); exp_fd.delete(); exp_busy.delete(); exp_ovf.delete();
    for (int i = 0; i < len; i++) begin
      exp_tx.push_back(1'b1); exp_fd.push_back(1'b0);
      exp_busy.push_back(1'b0); exp_ovf.push_back(1'b0);
    end
    for (int e = n0; e < n1; e++) begin
      pop = (e - 1 >= idle_from) && (q.size() > 0);
      if (k < edges.size() && edges[k] == e) begin
        if (q.size() < FIFO_DEPTH || pop) q.push_back(stim_dat[k]);
        else ovf = 1'b1;
        k++;
      end
      if (pop) begin
        b = q.pop_front();
        s = e + 1;
        for (int j = 0; j < NBITS; j++)
          for (int c = 0; c < BIT_CLKS; c++) begin
            idx = s + j * BIT_CLKS + c - n0;
            if (idx < len) exp_tx[idx] = bit_level(b, j);
          end
        idle_from = e + FRAME_CLKS + 1;
        sent++;
        idx = s + FRAME_CLKS - 1 - n0;
        if (sent % FRAME_PIX == 0 && idx < len) exp_fd[idx] = 1'b1;
      end
      exp_busy[e-n0] = (q.size() > 0) || (e < idle_from);
      exp_ovf[e-n0]  = ovf;
    end
  endtask

  function automatic logic [3:0] exp_at(input int i);
    return {exp_ovf[i], exp_busy[i], exp_fd[i], exp_tx[i]};
  endfunction

  function automatic int first_diff(input int n0);
    for (int i = 0; i < exp_tx.size(); i++)
      if (obs_log[n0+i] !== exp_at(i)) return i;
    return -1;
  endfunction

  function automatic int count_frames(input int from, input int to);
    int n = 0;
    int i = from;
    while (i < to) begin
      if (obs_log[i][0] == 1'b0) begin n++; i += FRAME_CLKS; end
      else i++;
    end
    return n;
  endfunction

  function automatic int count_fd(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) if (obs_log[i][1]) n++;
    return n;
  endfunction

  // Drives the queued stimulus, waits for the block to drain, runs the model.
  task automatic run_case(output int n0, output int n1);
    int waited;
    edges.delete();
    n0 = obs_log.size();
    for (int k = 0; k < stim_dat.size(); k++) begin
      if (stim_gap[k] > 0) begin
        pix.pi_flag = 1'b0;
        repeat (stim_gap[k]) @(negedge sys_clk);
      end
      pix.pi_flag = 1'b1;
      pix.pi_data = stim_dat[k];
      edges.push_back(obs_log.size());
      @(negedge sys_clk);
    end
    pix.pi_flag = 1'b0;
    waited = 0;
    while (po_busy && waited < 20000) begin
      @(negedge sys_clk);
      waited++;
    end
    if (po_busy) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: po_busy still %b after %0d cycles, required 0", po_busy, waited);
    end
    repeat (4) @(negedge sys_clk);
    n1 = obs_log.size();
    model(n0, n1);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n   = 1'b0;
    pix.pi_flag = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic clear_stim();
    stim_gap.delete();
    stim_dat.delete();
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    sys_rst_n   = 1'b0;
    pix.pi_flag = 1'b0;
    pix.pi_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    vectors++; if (tx !== 1'b1)          begin miscompares++; $display("FAIL reset_tx: got %b, required 1", tx); end
    vectors++; if (po_busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b, required 0", po_busy); end
    vectors++; if (po_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b, required 0", po_overflow); end
    vectors++; if (frame_done !== 1'b0)  begin miscompares++; $display("FAIL reset_fd: got %b, required 0", frame_done); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_single();
    int n0, n1, d;
    do_reset();
    clear_stim();
    stim_gap.push_back(0); stim_dat.push_back(8'hA5);
    run_case(n0, n1);
    vectors++; if (obs_log[n0+1][0] !== 1'b1) begin miscompares++; $display("FAIL single_pre_start: tx after edge 1 = %b, required 1", obs_log[n0+1][0]); end
    vectors++; if (obs_log[n0+2][0] !== 1'b0) begin miscompares++; $display("FAIL single_start: tx after edge 2 = %b, required 0", obs_log[n0+2][0]); end
    d = first_diff(n0);
    vectors++; if (d != -1) begin miscompares++; $display("FAIL single_trace: cycle %0d got %b, required %b", d, obs_log[n0+d], exp_at(d)); end
  endtask

  task automatic test_burst();
    int n0, n1, d;
    do_reset();
    clear_stim();
    for (int i = 0; i < 16; i++) begin stim_gap.push_back(0); stim_dat.push_back(i[7:0]); end
    run_case(n0, n1);
    d = first_diff(n0);
    vectors++; if (d != -1) begin miscompares++; $display("FAIL burst_trace: cycle %0d got %b, required %b", d, obs_log[n0+d], exp_at(d)); end
    vectors++; if (count_frames(n0, n1) != 16) begin miscompares++; $display("FAIL burst_count: got %0d frames, required 16", count_frames(n0, n1)); end
    vectors++; if (po_overflow !== 1'b0) begin miscompares++; $display("FAIL burst_ovf: got %b, required 0", po_overflow); end
  endtask

  task automatic test_overflow();
    int n0, n1, d;
    do_reset();
    clear_stim();
    for (int i = 0; i < 20; i++) begin stim_gap.push_back(0); stim_dat.push_back(i[7:0]); end
    run_case(n0, n1);
    d = first_diff(n0);
    vectors++; if (d != -1) begin miscompares++; $display("FAIL ovf_trace: cycle %0d got %b, required %b", d, obs_log[n0+d], exp_at(d)); end
    vectors++; if (count_frames(n0, n1) != 17) begin miscompares++; $display("FAIL ovf_count: got %0d frames, required 17", count_frames(n0, n1)); end
    vectors++; if (po_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b, required 1", po_overflow); end
    do_reset();
    vectors++; if (po_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b after reset, required 0", po_overflow); end
  endtask

  task automatic test_frame_done();
    int n0, n1, d;
    do_reset();
    clear_stim();
    for (int i = 0; i < 8; i++) begin
      stim_gap.push_back($urandom_range(0, 3));
      stim_dat.push_back(8'($urandom));
    end
    run_case(n0, n1);
    d = first_diff(n0);
    vectors++; if (d != -1) begin miscompares++; $display("FAIL frame_trace: cycle %0d got %b, required %b", d, obs_log[n0+d], exp_at(d)); end
    vectors++; if (count_fd(n0, n1) != 2) begin miscompares++; $display("FAIL frame_pulses: got %0d cycles high, required 2", count_fd(n0, n1)); end
  endtask

  task automatic test_random();
    int n0, n1, d, nb;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      clear_stim();
      nb = $urandom_range(6, 14);
      for (int i = 0; i < nb; i++) begin
        stim_gap.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 150) : 0);
        stim_dat.push_back(8'($urandom));
      end
      run_case(n0, n1);
      d = first_diff(n0);
      vectors++; if (d != -1) begin miscompares++; $display("FAIL random_trace[%0d]: cycle %0d got %b, required %b", it, d, obs_log[n0+d], exp_at(d)); end
    end
  endtask

  task automatic test_reset_mid();
    int n0, n1, d, target;
    do_reset();
    n0 = obs_log.size();
    pix.pi_flag = 1'b1;
    pix.pi_data = 8'($urandom);
    @(negedge sys_clk);
    pix.pi_flag = 1'b0;
    // Middle of data bit 3: start bit begins after edge 2, then 3 full data bits.
    target = n0 + 2 + 4 * BIT_CLKS + BIT_CLKS / 2;
    while (obs_log.size() < target) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    vectors++; if (tx !== 1'b1)      begin miscompares++; $display("FAIL midrst_tx: got %b, required 1", tx); end
    vectors++; if (po_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b, required 0", po_busy); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    clear_stim();
    stim_gap.push_back(0); stim_dat.push_back(8'h3C);
    run_case(n0, n1);
    d = first_diff(n0);
    vectors++; if (d != -1) begin miscompares++; $display("FAIL midrst_trace: cycle %0d got %b, required %b", d, obs_log[n0+d], exp_at(d)); end
    vectors++; if (count_frames(n0, n1) != 1) begin miscompares++; $display("FAIL midrst_count: got %0d frames, required 1", count_frames(n0, n1)); end
  endtask

`ifdef SOBEL_TX_PARITY_EN
  task automatic test_parity();
    int n0, n1, d, s1, s2;
    do_reset();
    clear_stim();
    stim_gap.push_back(0); stim_dat.push_back(8'h07);
    stim_gap.push_back(0); stim_dat.push_back(8'h03);
    run_case(n0, n1);
    s1 = n0 + 2;
    s2 = s1 + FRAME_CLKS + 2;
    vectors++; if (obs_log[s1 + 9*BIT_CLKS + BIT_CLKS/2][0] !== 1'b1) begin miscompares++; $display("FAIL parity_07: got %b, required 1", obs_log[s1 + 9*BIT_CLKS + BIT_CLKS/2][0]); end
    vectors++; if (obs_log[s2 + 9*BIT_CLKS + BIT_CLKS/2][0] !== 1'b0) begin miscompares++; $display("FAIL parity_03: got %b, required 0", obs_log[s2 + 9*BIT_CLKS + BIT_CLKS/2][0]); end
    d = first_diff(n0);
    vectors++; if (d != -1) begin miscompares++; $display("FAIL parity_trace: cycle %0d got %b, required %b", d, obs_log[n0+d], exp_at(d)); end
  endtask
`endif

  initial begin
    pix.pi_flag = 1'b0;
    pix.pi_data = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_frame_done();
    test_reset_mid();
    test_random();
`ifdef SOBEL_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
